// File: rtl/noise_mem_sched.sv
// noise_mem_sched: fill/read sequencer for the x/y/z noise BRAM bank array.
// Fills all 8 words of the enabled banks with LFSR words, then hands out one
// bank/address per accepted read. Refills happen on command or automatically
// after a programmable number of accepted reads.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_EMPTY | BRAM contents not valid, waiting for a refill request
//   ST_FILL  | writing addresses 0..7 of every enabled bank, LFSR stepping
//   ST_READY | serving reads, rotating address then bank
module noise_mem_sched #(
  parameter int pBANKS        = 16,
  parameter int pREFILL_READS = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] I_seed,
  input  logic        I_seed_load,
  input  logic [15:0] I_bank_mask,
  input  logic        I_refill,
  input  logic        I_rd_req,
  output logic        O_rd_ready,
  output logic        O_rd_valid,
  output logic        O_filling,
  output logic        O_err,
  output logic [2:0]  O_wr_addr,
  output logic [2:0]  O_rd_addr,
  output logic        O_wr_en,
  output logic [15:0] O_enable,
  output logic [31:0] O_lfsr_state,
  output logic [3:0]  O_rd_bank
);

  // Galois taps for x^32+x^22+x^2+x+1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] MASK_LIM32 = (pBANKS >= 16) ? 32'h0000_FFFF
                                                      : ((32'd1 << pBANKS) - 32'd1);
  localparam logic [15:0] MASK_LIM   = MASK_LIM32[15:0];
  localparam bit          AUTO_EN    = (pREFILL_READS != 0);
  localparam logic [15:0] REFILL_N   = 16'(pREFILL_READS);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_lfsr;
  logic [15:0] r_mask;
  logic [2:0]  r_fill_addr;
  logic [2:0]  r_rd_ptr;
  logic [3:0]  r_bank_ptr;
  logic [3:0]  r_rd_bank;
  logic        r_rd_valid;
  logic [15:0] r_rd_cnt;
  logic        r_err;

  logic [15:0] w_mask_eff;
  logic        w_mask_has;
  logic        w_auto_hit;
  logic        w_accept;
  logic        w_start;
  logic        w_fill_done;
  logic        w_err;
  logic [31:0] w_lfsr_step;

  function automatic logic [3:0] f_lowest(input logic [15:0] mask);
    logic [3:0] v;
    v = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) v = 4'(i);
    end
    return v;
  endfunction

  // next enabled bank strictly above cur, wrapping to the lowest enabled bank
  function automatic logic [3:0] f_next_bank(input logic [15:0] mask, input logic [3:0] cur);
    logic [3:0] v;
    logic       found;
    v     = f_lowest(mask);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && mask[i] && (i > int'(cur))) begin
        v     = 4'(i);
        found = 1'b1;
      end
    end
    return v;
  endfunction

  assign w_mask_eff  = I_bank_mask & MASK_LIM;
  assign w_mask_has  = (w_mask_eff != 16'd0);
  assign w_auto_hit  = AUTO_EN && (r_rd_cnt == REFILL_N);
  assign w_lfsr_step = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);

  // Ready drops in the cycle after the last counted read so no extra read slips in
  assign O_rd_ready = (r_state == ST_READY) && !w_auto_hit;
  assign w_accept   = I_rd_req && O_rd_ready;

  // Next-state decode; an accept coinciding with a refill still completes
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_fill_done  = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (I_refill) begin
          if (w_mask_has) begin
            w_next_state = ST_FILL;
            w_start      = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      ST_FILL: begin
        if (r_fill_addr == 3'd7) begin
          w_next_state = ST_READY;
          w_fill_done  = 1'b1;
        end
      end
      ST_READY: begin
        if (w_auto_hit) begin
          if (w_mask_has) begin
            w_next_state = ST_FILL;
            w_start      = 1'b1;
          end else begin
            w_next_state = ST_EMPTY;
            w_err        = 1'b1;
          end
        end else if (I_refill) begin
          if (w_mask_has) begin
            w_next_state = ST_FILL;
            w_start      = 1'b1;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      default: w_next_state = ST_EMPTY;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  // LFSR: seed load wins over stepping; an all-zero seed would lock up, so it maps to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 32'h1;
    end else if (I_seed_load) begin
      r_lfsr <= (I_seed == 32'd0) ? 32'h1 : I_seed;
    end else if (r_state == ST_FILL) begin
      r_lfsr <= w_lfsr_step;
    end
  end

  // Fill bookkeeping: mask is frozen for the whole fill and the read rotation after it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask      <= 16'd0;
      r_fill_addr <= 3'd0;
    end else if (w_start) begin
      r_mask      <= w_mask_eff;
      r_fill_addr <= 3'd0;
    end else if (r_state == ST_FILL) begin
      r_fill_addr <= r_fill_addr + 3'd1;
    end
  end

  // Read rotation: address first, bank on address wrap; bank output held between accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr   <= 3'd0;
      r_bank_ptr <= 4'd0;
      r_rd_bank  <= 4'd0;
      r_rd_cnt   <= 16'd0;
    end else if (w_fill_done) begin
      r_rd_ptr   <= 3'd0;
      r_bank_ptr <= f_lowest(r_mask);
      r_rd_cnt   <= 16'd0;
    end else if (w_accept) begin
      r_rd_bank <= r_bank_ptr;
      r_rd_ptr  <= r_rd_ptr + 3'd1;
      if (r_rd_ptr == 3'd7) r_bank_ptr <= f_next_bank(r_mask, r_bank_ptr);
      if (r_rd_cnt != 16'hFFFF) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  // One-cycle pulses: read data valid after accept, error on empty-mask refill
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= w_accept;
      r_err      <= w_err;
    end
  end

  assign O_filling    = (r_state == ST_FILL);
  assign O_wr_en      = (r_state == ST_FILL);
  assign O_wr_addr    = (r_state == ST_FILL) ? r_fill_addr : 3'd0;
  assign O_enable     = (r_state == ST_FILL) ? r_mask : 16'd0;
  assign O_lfsr_state = (r_state == ST_FILL) ? r_lfsr : 32'd0;
  assign O_rd_addr    = r_rd_ptr;
  assign O_rd_bank    = r_rd_bank;
  assign O_rd_valid   = r_rd_valid;
  assign O_err        = r_err;

endmodule

// File: tb/tb_noise_mem_sched.sv
// Bench for noise_mem_sched: default instance plus a 4-bank / 4-read instance
// sharing the same stimulus.
module tb_noise_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] I_seed;
  logic        I_seed_load, I_refill, I_rd_req;
  logic [15:0] I_bank_mask;

  logic        rd_ready, rd_valid, filling, err, wr_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] enable;
  logic [31:0] lfsr_state;
  logic [3:0]  rd_bank;

  logic        rd_ready_b, rd_valid_b, filling_b, err_b, wr_en_b;
  logic [2:0]  wr_addr_b, rd_addr_b;
  logic [15:0] enable_b;
  logic [31:0] lfsr_state_b;
  logic [3:0]  rd_bank_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_lfsr;
  int          m_k;
  logic [15:0] m_mask;
  logic [3:0]  m_last_bank;

  always #5 clk = ~clk;

  noise_mem_sched dut (
    .clk(clk), .rst_n(rst_n), .I_seed(I_seed), .I_seed_load(I_seed_load),
    .I_bank_mask(I_bank_mask), .I_refill(I_refill), .I_rd_req(I_rd_req),
    .O_rd_ready(rd_ready), .O_rd_valid(rd_valid), .O_filling(filling), .O_err(err),
    .O_wr_addr(wr_addr), .O_rd_addr(rd_addr), .O_wr_en(wr_en), .O_enable(enable),
    .O_lfsr_state(lfsr_state), .O_rd_bank(rd_bank)
  );

  noise_mem_sched #(.pBANKS(4), .pREFILL_READS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .I_seed(I_seed), .I_seed_load(I_seed_load),
    .I_bank_mask(I_bank_mask), .I_refill(I_refill), .I_rd_req(I_rd_req),
    .O_rd_ready(rd_ready_b), .O_rd_valid(rd_valid_b), .O_filling(filling_b), .O_err(err_b),
    .O_wr_addr(wr_addr_b), .O_rd_addr(rd_addr_b), .O_wr_en(wr_en_b), .O_enable(enable_b),
    .O_lfsr_state(lfsr_state_b), .O_rd_bank(rd_bank_b)
  );

  // Polynomial x^32+x^22+x^2+x+1: shift out bit 0; when it is 1, fold it back
  // into the positions of the x^32, x^22, x^2 and x^1 terms.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] v;
    v = s >> 1;
    if (s[0]) v = v ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return v;
  endfunction

  // k-th read after a fill: 8 addresses per enabled bank, banks in ascending order
  function automatic logic [3:0] bank_of(input logic [15:0] mask, input int k);
    int bits[$];
    for (int i = 0; i < 16; i++) if (mask[i]) bits.push_back(i);
    return 4'(bits[(k / 8) % bits.size()]);
  endfunction

  task automatic apply_reset();
    I_seed = 32'd0; I_seed_load = 1'b0; I_refill = 1'b0; I_rd_req = 1'b0;
    I_bank_mask = 16'd0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_lfsr = 32'h1; m_k = 0; m_last_bank = 4'd0; m_mask = 16'd0;
  endtask

  // Refill was applied at the previous negedge; walk and check the 8 fill cycles.
  task automatic check_fill_cycles(input logic [15:0] mask, input bit hold, input bit exp_v0,
                                   input int load_at, input logic [31:0] load_val);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) I_rd_req = 1'b0;
      if (!(hold && c < 7)) I_refill = 1'b0;
      if (c == load_at + 1) I_seed_load = 1'b0;
      n_checks++;
      if ({filling, wr_en, rd_ready, wr_addr, enable} !== {1'b1, 1'b1, 1'b0, 3'(c), mask}) begin
        n_fail++;
        $display("FAIL fill_ctrl c=%0d got fil/we/rdy/addr/en=%b/%b/%b/%0d/%h exp 1/1/0/%0d/%h",
                 c, filling, wr_en, rd_ready, wr_addr, enable, c, mask);
      end
      n_checks++;
      if (lfsr_state !== m_lfsr) begin
        n_fail++;
        $display("FAIL fill_lfsr c=%0d got %h exp %h", c, lfsr_state, m_lfsr);
      end
      n_checks++;
      if (rd_valid !== ((c == 0) ? exp_v0 : 1'b0) || rd_bank !== m_last_bank) begin
        n_fail++;
        $display("FAIL fill_rd c=%0d got valid=%b bank=%0d exp valid=%b bank=%0d",
                 c, rd_valid, rd_bank, (c == 0) ? exp_v0 : 1'b0, m_last_bank);
      end
      if (c == load_at) begin
        I_seed = load_val; I_seed_load = 1'b1;
        m_lfsr = (load_val == 32'd0) ? 32'h1 : load_val;
      end else begin
        m_lfsr = lfsr_next(m_lfsr);
      end
    end
    I_seed_load = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({rd_ready, filling, wr_en, enable} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      n_fail++;
      $display("FAIL fill_end got rdy/fil/we/en=%b/%b/%b/%h exp 1/0/0/0000",
               rd_ready, filling, wr_en, enable);
    end
    m_k = 0; m_mask = mask;
  endtask

  task automatic do_fill(input logic [15:0] mask, input bit hold);
    @(negedge clk);
    I_bank_mask = mask; I_refill = 1'b1;
    check_fill_cycles(mask, hold, 1'b0, -1, 32'd0);
  endtask

  task automatic do_reads(input int n, input bit gaps);
    int acc = 0;
    bit pend = 1'b0;
    for (int cyc = 0; cyc < n * 4 + 4 && (acc < n || pend); cyc++) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== pend || rd_bank !== m_last_bank || rd_addr !== 3'(m_k % 8) ||
          rd_ready !== (m_k < 64)) begin
        n_fail++;
        $display("FAIL read k=%0d got valid=%b bank=%0d addr=%0d rdy=%b exp %b/%0d/%0d/%b",
                 m_k, rd_valid, rd_bank, rd_addr, rd_ready, pend, m_last_bank, m_k % 8, m_k < 64);
      end
      pend = 1'b0;
      if (acc < n && (!gaps || $urandom_range(0, 2) != 0)) begin
        I_rd_req = 1'b1;
        m_last_bank = bank_of(m_mask, m_k);
        m_k++; acc++; pend = 1'b1;
      end else begin
        I_rd_req = 1'b0;
      end
    end
    I_rd_req = 1'b0;
    n_checks++;
    if (acc != n) begin
      n_fail++;
      $display("FAIL read_budget got %0d reads exp %0d", acc, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    I_seed = 32'hFFFF_FFFF; I_seed_load = 1'b0; I_refill = 1'b0; I_rd_req = 1'b1;
    I_bank_mask = 16'hFFFF;
    #3;
    n_checks++;
    if ({rd_ready, rd_valid, filling, err, wr_addr, rd_addr, wr_en, enable, lfsr_state, rd_bank,
         rd_ready_b, rd_valid_b, filling_b, err_b, wr_en_b, enable_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b fil=%b we=%b en=%h lfsr=%h bank=%0d exp all zero",
               rd_ready, filling, wr_en, enable, lfsr_state, rd_bank);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, rd_valid, filling, wr_en} !== 4'b0000) begin
        n_fail++;
        $display("FAIL empty_no_read got rdy/valid/fil/we=%b%b%b%b exp 0000",
                 rd_ready, rd_valid, filling, wr_en);
      end
    end
    I_rd_req = 1'b0;
  endtask

  task automatic test_fill_and_back_to_back();
    apply_reset();
    @(negedge clk); I_seed = 32'h1; I_seed_load = 1'b1;
    @(negedge clk); I_seed_load = 1'b0; m_lfsr = 32'h1;
    do_fill(16'h0005, 1'b0);
    do_reads(16, 1'b0);
    n_checks++;
    if (rd_bank !== 4'd2) begin
      n_fail++;
      $display("FAIL b2b_last_bank got %0d exp 2", rd_bank);
    end
  endtask

  task automatic test_auto_refill();
    apply_reset();
    do_fill(16'h0005, 1'b0);
    @(negedge clk); I_rd_req = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 4) I_rd_req = 1'b0;
      n_checks++;
      if ({rd_valid_b, rd_ready_b, filling_b, rd_bank_b} !== {1'b1, (i < 4), 1'b0, 4'd0}) begin
        n_fail++;
        $display("FAIL auto_reads i=%0d got valid/rdy/fil/bank=%b/%b/%b/%0d exp 1/%b/0/0",
                 i, rd_valid_b, rd_ready_b, filling_b, rd_bank_b, i < 4);
      end
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if ({filling_b, wr_en_b, rd_ready_b, rd_valid_b, wr_addr_b} !== {4'b1100, 3'(c)}) begin
        n_fail++;
        $display("FAIL auto_fill c=%0d got fil/we/rdy/valid/addr=%b/%b/%b/%b/%0d exp 1/1/0/0/%0d",
                 c, filling_b, wr_en_b, rd_ready_b, rd_valid_b, wr_addr_b, c);
      end
    end
    @(negedge clk);
    n_checks++;
    if ({rd_ready_b, filling_b} !== 2'b10) begin
      n_fail++;
      $display("FAIL auto_ready got rdy/fil=%b%b exp 10", rd_ready_b, filling_b);
    end
  endtask

  task automatic test_refill_coincide();
    apply_reset();
    do_fill(16'h0102, 1'b0);
    do_reads(5, 1'b1);
    @(negedge clk);
    I_rd_req = 1'b1; I_refill = 1'b1;
    m_last_bank = bank_of(m_mask, m_k);
    check_fill_cycles(16'h0102, 1'b0, 1'b1, -1, 32'd0);
    do_reads(9, 1'b0);
  endtask

  task automatic test_empty_mask();
    apply_reset();
    @(negedge clk); I_bank_mask = 16'h0000; I_refill = 1'b1;
    @(negedge clk); I_refill = 1'b0;
    n_checks++;
    if ({err, wr_en, filling, rd_ready} !== 4'b1000) begin
      n_fail++;
      $display("FAIL err_empty got err/we/fil/rdy=%b%b%b%b exp 1000", err, wr_en, filling, rd_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({err, filling, rd_ready} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_pulse_empty got err/fil/rdy=%b%b%b exp 000", err, filling, rd_ready);
    end
    do_fill(16'h0005, 1'b0);
    @(negedge clk); I_bank_mask = 16'h0000; I_refill = 1'b1;
    @(negedge clk); I_refill = 1'b0;
    n_checks++;
    if ({err, wr_en, filling, rd_ready} !== 4'b1001) begin
      n_fail++;
      $display("FAIL err_ready got err/we/fil/rdy=%b%b%b%b exp 1001", err, wr_en, filling, rd_ready);
    end
    @(negedge clk);
    n_checks++;
    if ({err, filling, rd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL err_pulse_ready got err/fil/rdy=%b%b%b exp 001", err, filling, rd_ready);
    end
    // Bits above pBANKS-1 do not count: the 4-bank instance sees an empty mask.
    apply_reset();
    @(negedge clk); I_bank_mask = 16'h0030; I_refill = 1'b1;
    @(negedge clk); I_refill = 1'b0;
    n_checks++;
    if ({err_b, filling_b, err, filling, enable} !== {4'b1001, 16'h0030}) begin
      n_fail++;
      $display("FAIL mask_limit got err_b/fil_b/err/fil=%b%b%b%b en=%h exp 1001 en=0030",
               err_b, filling_b, err, filling, enable);
    end
  endtask

  task automatic test_reset_mid_fill();
    apply_reset();
    @(negedge clk); I_bank_mask = 16'h0005; I_refill = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      I_refill = 1'b0;
    end
    n_checks++;
    if (wr_addr !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_fill_addr got %0d exp 3", wr_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rd_ready, rd_valid, filling, err, wr_addr, rd_addr, wr_en, enable, lfsr_state,
         rd_bank} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got fil=%b we=%b addr=%0d en=%h lfsr=%h exp all zero",
               filling, wr_en, wr_addr, enable, lfsr_state);
    end
    @(negedge clk); rst_n = 1'b1; I_rd_req = 1'b1;
    m_lfsr = 32'h1; m_k = 0; m_last_bank = 4'd0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({rd_ready, rd_valid, filling} !== 3'b000) begin
        n_fail++;
        $display("FAIL post_reset_empty got rdy/valid/fil=%b%b%b exp 000", rd_ready, rd_valid, filling);
      end
    end
    I_rd_req = 1'b0;
    do_fill(16'h0005, 1'b0);
  endtask

  task automatic test_seed();
    int nw = 0;
    apply_reset();
    @(negedge clk); I_seed = 32'h1234_5678; I_seed_load = 1'b1;
    @(negedge clk); I_seed_load = 1'b0; m_lfsr = 32'h1234_5678;
    do_fill(16'h8001, 1'b0);
    @(negedge clk); I_seed = 32'd0; I_seed_load = 1'b1;
    @(negedge clk); I_seed_load = 1'b0; m_lfsr = 32'h1;
    @(negedge clk); I_bank_mask = 16'h8001; I_refill = 1'b1;
    check_fill_cycles(16'h8001, 1'b1, 1'b0, 2, 32'hA5A5_A5A5);
    repeat (6) begin
      @(negedge clk);
      if (wr_en) nw++;
    end
    n_checks++;
    if (nw != 0) begin
      n_fail++;
      $display("FAIL extra_writes got %0d exp 0", nw);
    end
    do_reads(16, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] s;
    logic [15:0] m;
    for (int it = 0; it < 5; it++) begin
      s = $urandom;
      if (it == 0) s = 32'd0;
      m = 16'($urandom_range(1, 65535));
      @(negedge clk); I_seed = s; I_seed_load = 1'b1;
      @(negedge clk); I_seed_load = 1'b0; m_lfsr = (s == 32'd0) ? 32'h1 : s;
      do_fill(m, 1'b0);
      do_reads($urandom_range(1, 40), 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_and_back_to_back();
    test_auto_refill();
    test_refill_coincide();
    test_empty_mask();
    test_reset_mid_fill();
    test_seed();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
